// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundles the IF/MEM pipeline request signals and the external
//            req/ack bus signals seen by the shared memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLCT_WIDTH = 4
);
  // IF-stage fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_data;
  logic                  if_ready;

  // MEM-stage load/store port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [SLCT_WIDTH-1:0] mem_byte_slct;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  // Pipeline freeze
  logic                  stall_req;

  // External bus
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [SLCT_WIDTH-1:0] bus_byte_slct;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  // Arbiter view
  modport master (
    input  if_req, if_addr,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_byte_slct,
    input  bus_ack, bus_rdata,
    output if_data, if_ready, mem_rdata, mem_ready, stall_req,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_byte_slct
  );

  // Pipeline + bus environment view
  modport slave (
    output if_req, if_addr,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_byte_slct,
    output bus_ack, bus_rdata,
    input  if_data, if_ready, mem_rdata, mem_ready, stall_req,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_byte_slct
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory bus port between instruction fetch and the
//            load/store path. Data accesses win ties, each port is served at
//            most once per pipeline cycle, and the pipeline is stalled until
//            every wanted access of the current cycle has completed.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLCT_WIDTH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  mem_port_arbiter_if.master   arb
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_D = 2'd1;
  localparam logic [1:0] S_BUSY_I = 2'd2;

  logic [1:0]            r_state;
  logic                  r_if_served;
  logic                  r_mem_served;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic [SLCT_WIDTH-1:0] r_bus_slct;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_mem_rdata;

  logic                  w_d_pend;
  logic                  w_i_pend;
  logic                  w_stall;
  logic                  w_ack_d;
  logic                  w_ack_i;

  // A port only counts as pending until it has been served in this
  // pipeline cycle; this is what keeps a frozen request from re-issuing.
  assign w_d_pend = (arb.mem_read | arb.mem_write) & ~r_mem_served;
  assign w_i_pend = arb.if_req & ~r_if_served;
  assign w_stall  = w_d_pend | w_i_pend;

  // Acks are only meaningful while an access is in flight.
  assign w_ack_d  = (r_state == S_BUSY_D) & arb.bus_ack;
  assign w_ack_i  = (r_state == S_BUSY_I) & arb.bus_ack;

  // Grant FSM and registered bus request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_slct  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // MEM holds the older instruction, so it wins a tie.
          if (w_d_pend) begin
            r_state     <= S_BUSY_D;
            r_bus_req   <= 1'b1;
            r_bus_we    <= arb.mem_write;
            r_bus_addr  <= arb.mem_addr;
            r_bus_wdata <= arb.mem_wdata;
            r_bus_slct  <= arb.mem_byte_slct;
          end else if (w_i_pend) begin
            r_state     <= S_BUSY_I;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= arb.if_addr;
            r_bus_wdata <= '0;
            r_bus_slct  <= '1;
          end
        end
        S_BUSY_D: begin
          if (arb.bus_ack) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
          end
        end
        S_BUSY_I: begin
          if (arb.bus_ack) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Served flags and held return data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_served  <= 1'b0;
      r_mem_served <= 1'b0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
    end else begin
      // Pipeline advances: start the next cycle with both ports unserved.
      if (!w_stall) begin
        r_if_served  <= 1'b0;
        r_mem_served <= 1'b0;
      end
      if (w_ack_d) begin
        r_mem_served <= 1'b1;
        // Store acks carry no meaningful data, keep the last load word.
        if (!r_bus_we) begin
          r_mem_rdata <= arb.bus_rdata;
        end
      end
      if (w_ack_i) begin
        r_if_served <= 1'b1;
        r_if_data   <= arb.bus_rdata;
      end
    end
  end

  assign arb.if_data       = r_if_data;
  assign arb.if_ready      = r_if_served;
  assign arb.mem_rdata     = r_mem_rdata;
  assign arb.mem_ready     = r_mem_served;
  assign arb.stall_req     = w_stall;
  assign arb.bus_req       = r_bus_req;
  assign arb.bus_we        = r_bus_we;
  assign arb.bus_addr      = r_bus_addr;
  assign arb.bus_wdata     = r_bus_wdata;
  assign arb.bus_byte_slct = r_bus_slct;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter: directed vector table,
//            reset/spurious-ack sequences and randomized pipeline cycles
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLCT_WIDTH(SW)) arb ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLCT_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  slct;
  } txn_t;

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        rd;
    logic        wr;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [3:0]  sl;
    int          dly;
    logic [31:0] e_if;
    logic [31:0] e_mem;
  } vec_t;

  int          n_vec    = 0;
  int          n_err    = 0;
  txn_t        txq[$];
  int          ack_delay = 0;
  bit          auto_en   = 1'b1;
  bit          man_ack   = 1'b0;
  logic [31:0] man_data  = '0;
  int          stab_err  = 0;

  // Memory contents returned by the bus model for reads.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h3C01_0001;
      32'h0000_0104: return 32'h8C22_0000;
      32'h0000_0200: return 32'hDEAD_BEEF;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: acks each request ack_delay cycles after it first appears,
  // logs the transaction and checks the request fields stay stable.
  initial begin : responder
    int   cnt;
    txn_t first;
    cnt = 0;
    arb.bus_ack   = 1'b0;
    arb.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (arb.bus_ack) begin
        arb.bus_ack = 1'b0;
        cnt = 0;
      end else if (man_ack) begin
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = man_data;
        man_ack = 1'b0;
      end else if (auto_en && arb.bus_req === 1'b1) begin
        if (cnt == 0) begin
          first = '{arb.bus_we, arb.bus_addr, arb.bus_wdata, arb.bus_byte_slct};
        end else if (arb.bus_we !== first.we || arb.bus_addr !== first.addr ||
                     arb.bus_wdata !== first.wdata || arb.bus_byte_slct !== first.slct) begin
          stab_err++;
        end
        if (cnt >= ack_delay) begin
          arb.bus_ack = 1'b1;
          if (arb.bus_we) arb.bus_rdata = $urandom;
          else            arb.bus_rdata = mem_word(arb.bus_addr);
          txq.push_back(first);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One pipeline cycle: hold requests until the stall drops, then check
  // latency, results and the exact bus transactions issued.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int n_exp;
    int idx;
    txq.delete();
    stab_err  = 0;
    ack_delay = v.dly;
    arb.if_req        = v.ifr;
    arb.if_addr       = v.ifa;
    arb.mem_read      = v.rd;
    arb.mem_write     = v.wr;
    arb.mem_addr      = v.ma;
    arb.mem_wdata     = v.wd;
    arb.mem_byte_slct = v.sl;
    n_exp = ((v.rd | v.wr) ? 1 : 0) + (v.ifr ? 1 : 0);
    #1;
    cyc = 0;
    while (arb.stall_req === 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " stall_cycles"}, cyc, n_exp * (2 + v.dly));
    chk({tag, " if_ready"},  32'(arb.if_ready),  32'(v.ifr));
    chk({tag, " mem_ready"}, 32'(arb.mem_ready), 32'(v.rd | v.wr));
    chk({tag, " if_data"},   arb.if_data,   v.e_if);
    chk({tag, " mem_rdata"}, arb.mem_rdata, v.e_mem);
    chk({tag, " txn_count"}, txq.size(), n_exp);
    chk({tag, " bus_stable"}, stab_err, 0);
    if (txq.size() == n_exp) begin
      idx = 0;
      if (v.rd | v.wr) begin
        chk({tag, " d_we"},    32'(txq[0].we), 32'(v.wr));
        chk({tag, " d_addr"},  txq[0].addr,  v.ma);
        chk({tag, " d_wdata"}, txq[0].wdata, v.wd);
        chk({tag, " d_slct"},  32'(txq[0].slct), 32'(v.sl));
        idx = 1;
      end
      if (v.ifr) begin
        chk({tag, " i_we"},   32'(txq[idx].we), 32'(1'b0));
        chk({tag, " i_addr"}, txq[idx].addr, v.ifa);
        chk({tag, " i_slct"}, 32'(txq[idx].slct), 32'(4'hF));
      end
    end
    arb.if_req    = 1'b0;
    arb.mem_read  = 1'b0;
    arb.mem_write = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " if_ready_clr"},  32'(arb.if_ready),  32'(1'b0));
    chk({tag, " mem_ready_clr"}, 32'(arb.mem_ready), 32'(1'b0));
    chk({tag, " bus_req_idle"},  32'(arb.bus_req),   32'(1'b0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[4];
    vec_t        v;
    logic [31:0] m_if;
    logic [31:0] m_mem;
    int          op;

    tbl[0] = '{ifr:1'b1, ifa:32'h100, rd:1'b0, wr:1'b0, ma:32'h0, wd:32'h0, sl:4'h0,
               dly:0, e_if:32'h3C01_0001, e_mem:32'h0};
    tbl[1] = '{ifr:1'b1, ifa:32'h104, rd:1'b1, wr:1'b0, ma:32'h200, wd:32'h0, sl:4'hF,
               dly:0, e_if:32'h8C22_0000, e_mem:32'hDEAD_BEEF};
    tbl[2] = '{ifr:1'b0, ifa:32'h0, rd:1'b0, wr:1'b1, ma:32'h300, wd:32'h0000_00AB, sl:4'b0001,
               dly:3, e_if:32'h8C22_0000, e_mem:32'hDEAD_BEEF};
    tbl[3] = '{ifr:1'b0, ifa:32'h0, rd:1'b0, wr:1'b0, ma:32'h0, wd:32'h0, sl:4'h0,
               dly:0, e_if:32'h8C22_0000, e_mem:32'hDEAD_BEEF};

    arb.if_req        = 1'b0;
    arb.if_addr       = '0;
    arb.mem_read      = 1'b0;
    arb.mem_write     = 1'b0;
    arb.mem_addr      = '0;
    arb.mem_wdata     = '0;
    arb.mem_byte_slct = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst bus_req",   32'(arb.bus_req),   32'(1'b0));
    chk("rst bus_we",    32'(arb.bus_we),    32'(1'b0));
    chk("rst if_ready",  32'(arb.if_ready),  32'(1'b0));
    chk("rst mem_ready", 32'(arb.mem_ready), 32'(1'b0));
    chk("rst bus_addr",  arb.bus_addr,  32'h0);
    chk("rst bus_wdata", arb.bus_wdata, 32'h0);
    chk("rst bus_slct",  32'(arb.bus_byte_slct), 32'h0);
    chk("rst if_data",   arb.if_data,   32'h0);
    chk("rst mem_rdata", arb.mem_rdata, 32'h0);
    chk("rst stall",     32'(arb.stall_req), 32'(1'b0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a fetch, then a late ack
    auto_en     = 1'b0;
    arb.if_req  = 1'b1;
    arb.if_addr = 32'h180;
    @(posedge clk);
    #1;
    chk("midrst bus_req_granted", 32'(arb.bus_req), 32'(1'b1));
    rst        = 1'b1;
    arb.if_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst bus_req_dropped", 32'(arb.bus_req), 32'(1'b0));
    rst      = 1'b0;
    man_data = 32'hCAFE_F00D;
    man_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst bus_req_after_ack", 32'(arb.bus_req),  32'(1'b0));
    chk("midrst if_ready",          32'(arb.if_ready), 32'(1'b0));
    chk("midrst if_data",           arb.if_data,       32'h0);
    chk("midrst stall",             32'(arb.stall_req), 32'(1'b0));
    auto_en = 1'b1;

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Spurious ack while idle
    man_data = 32'h0BAD_F00D;
    man_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur bus_req",   32'(arb.bus_req),   32'(1'b0));
    chk("spur if_ready",  32'(arb.if_ready),  32'(1'b0));
    chk("spur mem_ready", 32'(arb.mem_ready), 32'(1'b0));
    chk("spur if_data",   arb.if_data,   32'h8C22_0000);
    chk("spur mem_rdata", arb.mem_rdata, 32'hDEAD_BEEF);
    chk("spur stall",     32'(arb.stall_req), 32'(1'b0));

    // Randomized pipeline cycles against the held-data model
    m_if  = 32'h8C22_0000;
    m_mem = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      op    = $urandom_range(0, 2);
      v.rd  = (op == 1);
      v.wr  = (op == 2);
      v.ifr = 1'($urandom_range(0, 1));
      v.ifa = $urandom & 32'hFFFF_FFFC;
      v.ma  = $urandom & 32'hFFFF_FFFC;
      v.wd  = $urandom;
      v.sl  = 4'($urandom_range(1, 15));
      v.dly = $urandom_range(0, 3);
      if (v.ifr) m_if  = mem_word(v.ifa);
      if (v.rd)  m_mem = mem_word(v.ma);
      v.e_if  = m_if;
      v.e_mem = m_mem;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
